// File: rtl/fft_frame_sequencer_if.sv
// Sample-stream, FFT-burst and status signals between the audio front-end,
// the frame sequencer and the FFT core.
interface fft_frame_sequencer_if #(
  parameter int DW = 14
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          fft_di_en;
  logic [DW-1:0] fft_di_re;
  logic [DW-1:0] fft_di_im;
  logic          fft_do_en;
  logic          frame_start;
  logic          frame_done;
  logic [15:0]   frame_idx;
  logic          err;

  modport master (
    output s_valid, s_data, fft_do_en,
    input  s_ready, fft_di_en, fft_di_re, fft_di_im, frame_start, frame_done, frame_idx, err
  );

  modport slave (
    input  s_valid, s_data, fft_do_en,
    output s_ready, fft_di_en, fft_di_re, fft_di_im, frame_start, frame_done, frame_idx, err
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Cuts the audio stream into overlapping N-point frames, bursts each into the FFT
// and tracks FFT output bursts to bound the number of frames in flight.
module fft_frame_sequencer #(
  parameter int N      = 1024,
  parameter int HOP    = 256,
  parameter int DW     = 14,
  parameter int GAP    = 2,
  parameter int MAXOUT = 2
) (
  input logic                  clock,
  input logic                  reset,
  fft_frame_sequencer_if.slave bus
);
  localparam int AW = $clog2(2 * N);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(N);
  localparam int IW = $clog2(MAXOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wp_q, wp_d, bp_q, bp_d, fill_s;
  logic [CW-1:0] rcnt_q, rcnt_d, ocnt_q, ocnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [15:0]   frame_idx_q, frame_idx_d;
  logic          first_q, first_d, err_q, err_d, frame_done_q, frame_done_d;
  logic          rd_vld_q, rd_vld_d, rd_first_q, rd_first_d;
  logic          di_en_q, frame_start_q;
  logic [DW-1:0] di_re_q, ram_q;
  logic [DW-1:0] mem [2*N];
  logic [AW-1:0] rd_addr_s;
  logic          s_ready_s, wr_s, go_s, last_rd_s, do_hit_s, done_s;

  // s_ready is held low while reset is asserted so every output reads 0 in reset.
  assign fill_s    = wp_q - bp_q;
  assign s_ready_s = ~reset & (fill_s < PW'(2 * N));
  assign wr_s      = bus.s_valid & s_ready_s;
  assign go_s      = (fill_s >= PW'(N)) && (inflight_q < IW'(MAXOUT));
  assign rd_addr_s = bp_q[AW-1:0] + AW'(rcnt_q);
  assign do_hit_s  = bus.fft_do_en & (inflight_q != IW'(0));
  assign done_s    = do_hit_s & (ocnt_q == CW'(N - 1));

  // Frame FSM: the first read is issued from IDLE so data appears two edges after the N-th sample.
  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    gcnt_d      = gcnt_q;
    bp_d        = bp_q;
    frame_idx_d = frame_idx_q;
    first_d     = first_q;
    rd_vld_d    = 1'b0;
    rd_first_d  = 1'b0;
    last_rd_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_s) begin
          rd_vld_d   = 1'b1;
          rd_first_d = 1'b1;
          rcnt_d     = CW'(1);
          state_d    = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        rd_vld_d = 1'b1;
        rcnt_d   = rcnt_q + CW'(1);
        if (rcnt_q == CW'(N - 1)) begin
          last_rd_s   = 1'b1;
          bp_d        = bp_q + PW'(HOP);
          frame_idx_d = first_q ? 16'd0 : frame_idx_q + 16'd1;
          first_d     = 1'b0;
          gcnt_d      = GW'(0);
          state_d     = ST_GAP;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gcnt_q == GW'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Input pointer and FFT output tracking; inflight inc/dec on one cycle nets to zero.
  always_comb begin
    wp_d         = wr_s ? wp_q + PW'(1) : wp_q;
    ocnt_d       = do_hit_s ? ocnt_q + CW'(1) : ocnt_q;
    inflight_d   = inflight_q + IW'(last_rd_s) - IW'(done_s);
    err_d        = err_q | (bus.fft_do_en & (inflight_q == IW'(0)));
    frame_done_d = done_s;
  end

  // State registers and the registered FFT-side outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      wp_q          <= PW'(0);
      bp_q          <= PW'(0);
      rcnt_q        <= CW'(0);
      ocnt_q        <= CW'(0);
      gcnt_q        <= GW'(0);
      inflight_q    <= IW'(0);
      frame_idx_q   <= 16'd0;
      first_q       <= 1'b1;
      err_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_first_q    <= 1'b0;
      di_en_q       <= 1'b0;
      di_re_q       <= {DW{1'b0}};
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      bp_q          <= bp_d;
      rcnt_q        <= rcnt_d;
      ocnt_q        <= ocnt_d;
      gcnt_q        <= gcnt_d;
      inflight_q    <= inflight_d;
      frame_idx_q   <= frame_idx_d;
      first_q       <= first_d;
      err_q         <= err_d;
      frame_done_q  <= frame_done_d;
      rd_vld_q      <= rd_vld_d;
      rd_first_q    <= rd_first_d;
      di_en_q       <= rd_vld_q;
      di_re_q       <= rd_vld_q ? ram_q : {DW{1'b0}};
      frame_start_q <= rd_first_q;
    end
  end

  // Sample RAM, 2N deep; contents are discarded logically by the pointer reset.
  always_ff @(posedge clock) begin
    if (wr_s) begin
      mem[wp_q[AW-1:0]] <= bus.s_data;
    end
    ram_q <= mem[rd_addr_s];
  end

  assign bus.s_ready     = s_ready_s;
  assign bus.fft_di_en   = di_en_q;
  assign bus.fft_di_re   = di_re_q;
  assign bus.fft_di_im   = {DW{1'b0}};
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_idx   = frame_idx_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed scenario with random sample data; expected frames are slices of the
// accepted-sample history (frame j = samples j*HOP .. j*HOP+N-1).
module tb_fft_frame_sequencer;
  localparam int N = 1024, HOP = 256, DW = 14, GAP = 2, MAXOUT = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fft_frame_sequencer_if #(.DW(DW)) bus ();

  fft_frame_sequencer #(.N(N), .HOP(HOP), .DW(DW), .GAP(GAP), .MAXOUT(MAXOUT)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0, errors = 0;
  int cyc = 0, last_acc = 0, last_do = 0;
  logic [DW-1:0] stream[$];
  logic [DW-1:0] rx[$];
  int blen[$], bstart[$], bend[$];
  int cur_len = 0, fs_bad = 0, im_bad = 0, done_n = 0, done_cyc = 0;
  logic prev_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Burst monitor: records each FFT input burst and pulse timing.
  always @(negedge clock) begin
    if (reset) begin
      rx.delete(); blen.delete(); bstart.delete(); bend.delete();
      cur_len <= 0; fs_bad <= 0; im_bad <= 0; done_n <= 0; done_cyc <= 0; prev_en <= 1'b0;
    end else begin
      if (bus.frame_start !== (bus.fft_di_en & ~prev_en)) fs_bad <= fs_bad + 1;
      if (bus.fft_di_en === 1'b1) begin
        rx.push_back(bus.fft_di_re);
        if (prev_en !== 1'b1) begin
          bstart.push_back(cyc);
          cur_len <= 1;
        end else begin
          cur_len <= cur_len + 1;
        end
        if (bus.fft_di_im !== '0) im_bad <= im_bad + 1;
      end else if (prev_en === 1'b1) begin
        blen.push_back(cur_len);
        bend.push_back(cyc - 1);
      end
      if (bus.frame_done === 1'b1) begin
        done_n   <= done_n + 1;
        done_cyc <= cyc;
      end
      prev_en <= bus.fft_di_en;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after an edge, log an accepted sample after the next edge.
  task automatic cyc_step(input logic v, input logic [DW-1:0] d, input logic de);
    logic acc;
    bus.s_valid = v; bus.s_data = d; bus.fft_do_en = de;
    #1 acc = v & bus.s_ready;
    @(posedge clock); #1;
    if (acc === 1'b1) begin
      stream.push_back(d);
      last_acc = cyc;
    end
  endtask

  task automatic feed(input int count, input bit rnd, input bit gaps);
    int target;
    target = stream.size() + count;
    for (int t = 0; t < 20000 && stream.size() < target; t++)
      cyc_step(gaps ? ($urandom_range(3) != 0) : 1'b1,
               rnd ? DW'($urandom) : DW'(stream.size()), 1'b0);
    chk("feed", 64'(stream.size()), 64'(target));
  endtask

  task automatic wait_bursts(input int n, input string tag);
    for (int t = 0; t < 3000 && blen.size() < n; t++) cyc_step(1'b0, '0, 1'b0);
    chk(tag, 64'(blen.size()), 64'(n));
  endtask

  task automatic drive_do(input int n);
    for (int i = 0; i < n; i++) cyc_step(1'b0, '0, 1'b1);
    last_do = cyc;
    cyc_step(1'b0, '0, 1'b0);
  endtask

  // Raise reset mid-cycle, confirm outputs clear at once, release after a full clock.
  task automatic reset_mid(input string tag);
    #1 reset = 1'b1;
    #1 chk(tag, 64'({bus.fft_di_en, bus.frame_start, bus.frame_done, bus.err,
                     bus.fft_di_re, bus.fft_di_im, bus.frame_idx}), 64'd0);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    stream.delete();
    #1 chk("rel_ready", 64'(bus.s_ready), 64'd1);
    chk("rel_di_en", 64'(bus.fft_di_en), 64'd0);
  endtask

  function automatic int frame_bad(input int j);
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      if (j * N + i >= rx.size() || j * HOP + i >= stream.size()) bad++;
      else if (rx[j * N + i] !== stream[j * HOP + i]) bad++;
    end
    return bad;
  endfunction

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.fft_do_en = 1'b0;
    @(posedge clock); #1;
    reset_mid("rst_init");
    chk("rst_idx", 64'(bus.frame_idx), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);

    // Single frame from a ramp
    feed(N, 1'b0, 1'b0);
    wait_bursts(1, "b0_count");
    chk("b0_len", 64'(blen[0]), 64'(N));
    chk("b0_latency", 64'(bstart[0]), 64'(last_acc + 2));
    chk("b0_data", 64'(frame_bad(0)), 64'd0);
    chk("b0_idx", 64'(bus.frame_idx), 64'd0);

    // Overlapping second frame
    feed(HOP, 1'b0, 1'b0);
    wait_bursts(2, "b1_count");
    chk("b1_len", 64'(blen[1]), 64'(N));
    chk("b1_latency", 64'(bstart[1]), 64'(last_acc + 2));
    chk("b1_gap", 64'(bstart[1] - bend[0] - 1 >= GAP), 64'd1);
    chk("b1_data", 64'(frame_bad(1)), 64'd0);
    chk("b1_idx", 64'(bus.frame_idx), 64'd1);

    // Credit limit and backpressure
    for (int t = 0; t < 4000 && bus.s_ready === 1'b1; t++)
      cyc_step(1'b1, DW'(stream.size()), 1'b0);
    chk("full_fill", 64'(stream.size()), 64'(2 * N + 2 * HOP));
    chk("full_ready", 64'(bus.s_ready), 64'd0);
    repeat (8) cyc_step(1'b1, DW'(stream.size()), 1'b0);
    chk("full_hold", 64'(stream.size()), 64'(2 * N + 2 * HOP));
    chk("credit_bursts", 64'(bstart.size()), 64'd2);
    drive_do(N);
    chk("c_done_n", 64'(done_n), 64'd1);
    chk("c_done_cyc", 64'(done_cyc), 64'(last_do));
    wait_bursts(3, "b2_count");
    chk("b2_latency", 64'(bstart[2]), 64'(last_do + 2));
    chk("b2_data", 64'(frame_bad(2)), 64'd0);
    chk("b2_idx", 64'(bus.frame_idx), 64'd2);
    chk("b2_ready", 64'(bus.s_ready), 64'd1);
    chk("c_err", 64'(bus.err), 64'd0);
    chk("fs_align", 64'(fs_bad), 64'd0);
    chk("di_im_zero", 64'(im_bad), 64'd0);

    // Reset in the middle of a burst
    reset_mid("rst_t5");
    feed(N, 1'b1, 1'b0);
    for (int t = 0; t < 100 && bstart.size() == 0; t++) cyc_step(1'b0, '0, 1'b0);
    chk("mid_started", 64'(bstart.size()), 64'd1);
    for (int t = 0; t < N && bstart.size() > 0 && cyc < bstart[0] + 499; t++)
      cyc_step(1'b0, '0, 1'b0);
    chk("mid_di_en", 64'(bus.fft_di_en), 64'd1);
    reset_mid("rst_mid_burst");
    feed(N, 1'b1, 1'b1);
    wait_bursts(1, "r0_count");
    chk("r0_len", 64'(blen[0]), 64'(N));
    chk("r0_latency", 64'(bstart[0]), 64'(last_acc + 2));
    chk("r0_data", 64'(frame_bad(0)), 64'd0);
    chk("r0_idx", 64'(bus.frame_idx), 64'd0);

    // Spurious FFT output with nothing in flight
    drive_do(N);
    chk("r0_done_n", 64'(done_n), 64'd1);
    chk("r0_done_cyc", 64'(done_cyc), 64'(last_do));
    chk("pre_sp_err", 64'(bus.err), 64'd0);
    repeat (3) cyc_step(1'b0, '0, 1'b1);
    cyc_step(1'b0, '0, 1'b0);
    chk("sp_err", 64'(bus.err), 64'd1);
    repeat (10) cyc_step(1'b0, '0, 1'b0);
    chk("sp_err_sticky", 64'(bus.err), 64'd1);
    chk("sp_no_done", 64'(done_n), 64'd1);
    feed(HOP, 1'b1, 1'b1);
    wait_bursts(2, "r1_count");
    chk("r1_data", 64'(frame_bad(1)), 64'd0);
    chk("r1_idx", 64'(bus.frame_idx), 64'd1);
    drive_do(N);
    chk("r1_done_n", 64'(done_n), 64'd2);
    chk("r1_done_cyc", 64'(done_cyc), 64'(last_do));
    chk("r1_err", 64'(bus.err), 64'd1);
    chk("r_fs_align", 64'(fs_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
